// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops bytes from an 8-bit synchronous FIFO (read latency 1),
// packs BYTES of them little-endian into one word and presents the word on a
// valid/ready stream. A flush pulse emits buffered tail bytes as a partial
// word with a matching byte-keep mask.
module fifo_rd_packer #(
  parameter int BYTES = 4,
  parameter int DW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic                fifo_rd_en,
  input  logic [DW-1:0]       fifo_rdata,
  input  logic                fifo_empty,
  output logic [DW*BYTES-1:0] out_data,
  output logic [BYTES-1:0]    out_keep,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                flush,
  output logic                busy
);

  localparam int              FW   = $clog2(BYTES + 1);
  localparam logic [FW-1:0]   FULL = FW'(BYTES);

  logic [DW*BYTES-1:0] asm_q, asm_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic                inflight_q;
  logic                flush_pending_q, flush_pending_d;
  logic [DW*BYTES-1:0] out_data_q, out_data_d;
  logic [BYTES-1:0]    out_keep_q, out_keep_d;
  logic                out_valid_q, out_valid_d;

  logic                xfer;
  logic                room;
  logic [FW:0]         occupancy;
  logic [BYTES-1:0]    lane_mask;
  logic [DW*BYTES-1:0] asm_masked;

  // Transfer decision and FIFO pop request from registered state only
  always_comb begin
    occupancy  = {1'b0, fill_q} + {{FW{1'b0}}, inflight_q};
    room       = occupancy < (FW+1)'(BYTES);
    xfer       = ((fill_q == FULL) ||
                  (flush_pending_q && (fill_q != '0) && !inflight_q)) &&
                 (!out_valid_q || out_ready);
    fifo_rd_en = !fifo_empty && (room || xfer);
  end

  // Keep mask and zero-padded copy of the filled assembly lanes
  always_comb begin
    lane_mask  = '0;
    asm_masked = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (i < 32'(fill_q)) begin
        lane_mask[i]              = 1'b1;
        asm_masked[i*DW +: DW]    = asm_q[i*DW +: DW];
      end
    end
  end

  // Assembly register: land the in-flight byte at lane fill, restart on transfer
  always_comb begin
    asm_d  = asm_q;
    fill_d = fill_q;
    if (inflight_q) begin
      if (xfer) begin
        // the word leaving this cycle is taken from asm_q, so lane 0 is free
        asm_d[DW-1:0] = fifo_rdata;
        fill_d        = FW'(1);
      end else begin
        for (int unsigned i = 0; i < BYTES; i++) begin
          if (i == 32'(fill_q)) begin
            asm_d[i*DW +: DW] = fifo_rdata;
          end
        end
        fill_d = fill_q + FW'(1);
      end
    end else if (xfer) begin
      fill_d = '0;
    end
  end

  // Output register, handshake and flush bookkeeping
  always_comb begin
    out_data_d      = out_data_q;
    out_keep_d      = out_keep_q;
    out_valid_d     = out_valid_q;
    flush_pending_d = flush_pending_q;
    if (xfer) begin
      out_data_d      = asm_masked;
      out_keep_d      = lane_mask;
      out_valid_d     = 1'b1;
      flush_pending_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (flush && ((fill_q != '0) || inflight_q)) begin
        flush_pending_d = 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q           <= '0;
      fill_q          <= '0;
      inflight_q      <= 1'b0;
      flush_pending_q <= 1'b0;
      out_data_q      <= '0;
      out_keep_q      <= '0;
      out_valid_q     <= 1'b0;
    end else begin
      asm_q           <= asm_d;
      fill_q          <= fill_d;
      inflight_q      <= fifo_rd_en;
      flush_pending_q <= flush_pending_d;
      out_data_q      <= out_data_d;
      out_keep_q      <= out_keep_d;
      out_valid_q     <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_valid = out_valid_q;
  assign busy      = (fill_q != '0) || inflight_q || flush_pending_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a behavioural FIFO feeds the DUT; every cycle is
// logged, and logged windows are checked against the FIFO write order.
module tb_fifo_rd_packer;
  localparam int BYTES = 4;
  localparam int DW    = 8;
  localparam int HMAX  = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rdata;
  logic        fifo_empty;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic        busy;
  logic        hold;

  int n_chk  = 0;
  int n_pass = 0;

  fifo_rd_packer #(.BYTES(BYTES), .DW(DW)) dut (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: array plus pointers, data one cycle after the pop
  logic [7:0] mem [0:1023];
  int wptr = 0;
  int rptr;
  assign fifo_empty = rst || hold || (wptr == rptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr       <= wptr;
      fifo_rdata <= 8'h00;
    end else if (fifo_rd_en) begin
      fifo_rdata <= mem[rptr];
      rptr       <= rptr + 1;
    end
  end

  // Per-cycle log sampled on the falling edge
  int          cyc = 0;
  logic        rs_h  [0:HMAX-1];
  logic        rd_h  [0:HMAX-1];
  logic        emp_h [0:HMAX-1];
  logic        vld_h [0:HMAX-1];
  logic        rdy_h [0:HMAX-1];
  logic        bsy_h [0:HMAX-1];
  logic [31:0] dat_h [0:HMAX-1];
  logic [3:0]  kp_h  [0:HMAX-1];

  always @(negedge clk) begin
    if (cyc < HMAX) begin
      rs_h[cyc]  <= rst;
      rd_h[cyc]  <= fifo_rd_en;
      emp_h[cyc] <= fifo_empty;
      vld_h[cyc] <= out_valid;
      rdy_h[cyc] <= out_ready;
      bsy_h[cyc] <= busy;
      dat_h[cyc] <= out_data;
      kp_h[cyc]  <= out_keep;
      cyc        <= cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wptr] = b;
    wptr      = wptr + 1;
  endtask

  // Results of the last scanned window
  int          exp_rd = 0;
  int          nw, nrd, nv, nbusy, first_rd, last_rd, first_v;
  logic [31:0] wd [0:255];
  logic [3:0]  wk [0:255];

  // Walk a logged window: gating, hold stability, scoreboard and statistics
  task automatic scan(input int c0, input int c1);
    logic [3:0] k;
    logic [7:0] lane;
    nw = 0; nrd = 0; nv = 0; nbusy = 0;
    first_rd = -1; last_rd = -1; first_v = -1;
    for (int c = c0; c < c1; c++) begin
      if (!rs_h[c]) begin
        if (emp_h[c]) check("rd_gate", rd_h[c], 0);
        if (rd_h[c]) begin
          nrd++;
          if (first_rd < 0) first_rd = c;
          last_rd = c;
        end
        if (bsy_h[c]) nbusy++;
        if (vld_h[c]) begin
          nv++;
          if (first_v < 0) first_v = c;
        end
        if (c > c0 && vld_h[c-1] && !rdy_h[c-1] && !rs_h[c-1]) begin
          check("hold_valid", vld_h[c], 1);
          check("hold_data", dat_h[c], dat_h[c-1]);
          check("hold_keep", kp_h[c], kp_h[c-1]);
        end
        if (vld_h[c] && rdy_h[c]) begin
          k = kp_h[c];
          if (nw < 256) begin
            wd[nw] = dat_h[c];
            wk[nw] = k;
          end
          nw++;
          check("keep_nonzero", k != 4'h0, 1);
          check("keep_contig", k & (k + 4'd1), 0);
          for (int i = 0; i < BYTES; i++) begin
            lane = dat_h[c][i*8 +: 8];
            if (k[i]) begin
              if (exp_rd < wptr) begin
                check("sb_byte", lane, mem[exp_rd]);
                exp_rd++;
              end else begin
                check("sb_underflow", 1, 0);
              end
            end else begin
              check("sb_pad", lane, 0);
            end
          end
        end
      end
    end
  endtask

  int c0;
  int guard;

  initial begin
    rst = 1'b1; out_ready = 1'b0; flush = 1'b0; hold = 1'b0;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_keep", out_keep, 0);
    check("rst_data", out_data, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    exp_rd = wptr;

    // Single full word
    out_ready = 1'b1;
    c0 = cyc;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (10) tick();
    scan(c0, cyc);
    check("A_rd_cnt", nrd, 4);
    check("A_rd_run", last_rd - first_rd, 3);
    check("A_nwords", nw, 1);
    check("A_data", wd[0], 32'h44332211);
    check("A_keep", wk[0], 4'hF);
    check("A_valid_cycles", nv, 1);
    check("A_latency", first_v - last_rd, 3);

    // Backpressure: 12 bytes with the sink stalled
    out_ready = 1'b0;
    c0 = cyc;
    for (int b = 1; b <= 12; b++) push(8'(b));
    repeat (20) tick();
    check("B_valid_stalled", out_valid, 1);
    check("B_data_stalled", out_data, 32'h04030201);
    scan(c0, cyc);
    check("B_rd_cnt", nrd, 8);
    check("B_nwords_stalled", nw, 0);
    out_ready = 1'b1;
    c0 = cyc;
    repeat (20) tick();
    scan(c0, cyc);
    check("B_nwords", nw, 3);
    check("B_word0", wd[0], 32'h04030201);
    check("B_word1", wd[1], 32'h08070605);
    check("B_word2", wd[2], 32'h0C0B0A09);
    check("B_all_bytes", exp_rd, wptr);

    // Flush of a two-byte tail
    c0 = cyc;
    push(8'hAA); push(8'hBB);
    repeat (6) tick();
    check("C_no_early_word", out_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    scan(c0, cyc);
    check("C_nwords", nw, 1);
    check("C_data", wd[0], 32'h0000BBAA);
    check("C_keep", wk[0], 4'h3);
    check("C_busy_end", busy, 0);

    // Flush coinciding with the pop of the second byte
    c0 = cyc;
    push(8'hAA);
    tick();
    tick();
    push(8'hCC);
    flush = 1'b1;
    #1;
    check("D_rd_with_flush", fifo_rd_en, 1);
    tick();
    flush = 1'b0;
    repeat (6) tick();
    scan(c0, cyc);
    check("D_nwords", nw, 1);
    check("D_data", wd[0], 32'h0000CCAA);
    check("D_keep", wk[0], 4'h3);

    // Flush with nothing buffered
    c0 = cyc;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("D2_busy_after", busy, 0);
    repeat (5) tick();
    scan(c0, cyc);
    check("D2_nvalid", nv, 0);
    check("D2_nbusy", nbusy, 0);

    // Asynchronous reset while a word is held and the next is filling
    out_ready = 1'b0;
    for (int b = 0; b < 6; b++) push(8'h51 + 8'(b));
    repeat (8) tick();
    check("E_valid_before", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("E_async_valid", out_valid, 0);
    check("E_async_keep", out_keep, 0);
    check("E_async_data", out_data, 0);
    check("E_async_rd_en", fifo_rd_en, 0);
    check("E_async_busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;
    exp_rd = wptr;
    out_ready = 1'b1;
    c0 = cyc;
    repeat (10) tick();
    scan(c0, cyc);
    check("E_no_stale_valid", nv, 0);
    check("E_no_reads", nrd, 0);

    // Random FIFO availability, sink readiness and flush pulses
    c0 = cyc;
    for (int t = 0; t < 200; t++) begin
      hold      = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) != 0 && wptr < 1000) push(8'($urandom));
      tick();
    end
    hold = 1'b0; out_ready = 1'b1; flush = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    guard = 0;
    while ((busy || out_valid || !fifo_empty) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("F_drain_timeout", 1, 0);
    repeat (3) tick();
    scan(c0, cyc);
    check("F_all_bytes", exp_rd, wptr);
    check("F_busy_end", busy, 0);
    check("F_valid_end", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Downstream consumer of the 8-bit synchronous FIFO.
- Pops bytes via the FIFO read port (rd_en / rdata / empty) and packs BYTES consecutive bytes into one wide word.
- Presents each word on a valid/ready output stream.
- A flush input forces out a partial word with a byte-keep mask, so tail data is never stranded.

Parameters:
- BYTES, 4: bytes per output word; legal range 2..8.
- DW, 8: FIFO data width; fixed at 8, present for clarity only.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; asynchronous, active-high.
- fifo_rd_en  out  1  FIFO pop request.
- fifo_rdata  in  DW  FIFO read data; valid the cycle after fifo_rd_en was high.
- fifo_empty  in  1  FIFO empty flag.
- out_data  out  DW*BYTES  packed word; byte 0 (first popped) in bits [7:0], little-endian.
- out_keep  out  BYTES  per-byte valid mask for out_data.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- flush  in  1  single-cycle request to emit buffered bytes as a partial word.
- busy  out  1  high when fill>0, a read is in flight, or flush is pending.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_keep=0, fifo_rd_en=0, busy=0, fill=0, inflight=0, flush_pending=0.
- Internal state:
  - assembly register asm[DW*BYTES] plus fill count (0..BYTES);
  - inflight flag, meaning a byte was popped last cycle;
  - output register (out_data/out_keep/out_valid);
  - flush_pending.
- FIFO read latency is fixed at 1.
  - fifo_rd_en high in cycle t -> fifo_rdata captured into asm byte lane [fill] at the end of cycle t+1; fill increments.
  - inflight = registered fifo_rd_en.
- Transfer event xfer, combinational: ((fill==BYTES) || (flush_pending && fill>0 && !inflight)) && (!out_valid || out_ready).
- On xfer:
  - out_data <= asm, with unfilled lanes zeroed;
  - out_keep <= (1<<fill)-1;
  - out_valid <= 1;
  - fill <= 0, or 1 if a byte lands in that same cycle (it goes to lane 0);
  - flush_pending <= 0.
- Output handshake:
  - out_valid && out_ready with no xfer -> out_valid <= 0.
  - While out_valid && !out_ready, out_data and out_keep are held stable.
- fifo_rd_en = !fifo_empty && (fill + inflight < BYTES || xfer). Combinational from registered state and fifo_empty only; never depends on out_ready combinationally except through xfer.
- Backpressure: the output register holds one word while asm fills the next. Reads stop when fill+inflight == BYTES. Maximum buffering is 2*BYTES bytes.
- Latency: a full word has out_valid high 3 cycles after its last fifo_rd_en, when the output is free.
- Flush:
  - flush sets flush_pending.
  - If fill==0 and inflight==0 when sampled, flush is ignored; empty words are never emitted.
  - A byte in flight lands first, then the partial word is emitted.
  - Flush while fill==BYTES is a normal full-word transfer.
- fifo_empty high blocks new reads; an in-flight byte is still captured.
- Reset mid-word: all buffered and in-flight bytes are discarded; the FIFO shares rst.

Test Plan:
- Reset: assert rst mid-fill -> out_valid=0, out_keep=0, fifo_rd_en=0, busy=0 immediately (async); no stale word appears after release.
- Single word: FIFO holds 0x11,0x22,0x33,0x44, out_ready=1 -> fifo_rd_en high 4 consecutive cycles. out_data=0x44332211, out_keep=4'b1111, out_valid for exactly 1 cycle, 3 cycles after the last rd_en.
- Backpressure: 12 bytes 0x01..0x0C, out_ready=0 -> out_data=0x04030201 held stable; fifo_rd_en stops after 8 pops. Raise out_ready -> 0x04030201, 0x08070605, 0x0C0B0A09 in order, no loss or duplication.
- Flush partial: pop 0xAA,0xBB then FIFO empty, pulse flush -> out_data=0x0000BBAA, out_keep=4'b0011, one word only.
- Flush timing: flush in the same cycle as fifo_rd_en for byte 0xCC with fill=1 (0xAA) -> single word 0x0000CCAA, keep=4'b0011. Flush with nothing buffered -> no out_valid, busy stays 0.
- Empty gating: fifo_empty toggles randomly over 200 cycles with ready toggling -> fifo_rd_en never high while fifo_empty=1; output bytes equal FIFO write order.
